// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and defaults for the fetch/LSU memory arbiter
//
// Purpose: FSM state and grant encodings plus the default wait-state count,
// shared by riscv_mem_arbiter and riscv_mem_wait_counter.
// Ports: none (package).
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_e;

  typedef enum logic {
    GNT_IF,
    GNT_LS
  } mem_grant_e;

  localparam int DEFAULT_WAIT = 3;

endpackage

// File: rtl/riscv_mem_wait_counter.sv
// rtl/riscv_mem_wait_counter.sv - wait-state counter for the shared memory access
//
// Purpose: counts enabled cycles of one memory access and flags the last one.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   clear  - restart the count at zero (asserted on every grant)
//   enable - advance the count by one
//   done   - high while count == WAIT-1, i.e. in the final wait-state cycle
module riscv_mem_wait_counter
  import riscv_mem_pkg::*;
#(
  parameter int WAIT = DEFAULT_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = $clog2(WAIT + 1);

  logic [CW-1:0] count;

  // Cleared on every grant, so it peaks at WAIT and never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == CW'(WAIT - 1));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - fetch/LSU arbiter and sequencer for one fixed-latency RAM
//
// Purpose: grants the shared single-port memory to the fetch or load/store
// requester, holds the memory enables for WAIT cycles, captures read data and
// returns a one-cycle ready pulse to the granted requester.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   if_req/if_addr                   - fetch request and word address
//   if_ready/if_rdata                - fetch completion pulse and data
//   ls_req/ls_we/ls_addr             - load/store request, store select, address
//   ls_wdata/ls_wstrb                - store data and byte enables
//   ls_ready/ls_rdata                - load/store completion pulse and load data
//   mem_en/mem_we/mem_addr           - memory enable, write enable, address
//   mem_wdata/mem_wstrb/mem_rdata    - memory write data, byte enables, read data
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int WAIT   = DEFAULT_WAIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_ready,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  mem_state_e        state_q, state_d;
  mem_grant_e        grant_q, last_grant_q, pick;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              cnt_en;
  logic              cnt_done;

  // Lone requester wins; on contention the one not served last time wins.
  always_comb begin
    pick = GNT_IF;
    if (if_req && ls_req) begin
      pick = (last_grant_q == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (ls_req) begin
      pick = GNT_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_en   = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    if_ready = 1'b0;
    ls_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_en = 1'b1;
        mem_en = 1'b1;
        // we_q is only ever set for LS grants; the grant gate keeps fetches read-only.
        mem_we = (grant_q == GNT_LS) && we_q;
        if (cnt_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if_ready = (grant_q == GNT_IF);
        ls_ready = (grant_q == GNT_LS);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= GNT_IF;
      last_grant_q <= GNT_IF;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
    end else begin
      if (accept) begin
        grant_q <= pick;
        addr_q  <= (pick == GNT_LS) ? ls_addr : if_addr;
        we_q    <= (pick == GNT_LS) && ls_we;
        wdata_q <= ls_wdata;
        wstrb_q <= ls_wstrb;
      end
      // Stores keep the previous read data visible on the rdata outputs.
      if ((state_q == BUSY) && cnt_done && !we_q) begin
        rdata_q <= mem_rdata;
      end
      if (state_q == DONE) begin
        last_grant_q <= grant_q;
      end
    end
  end

  riscv_mem_wait_counter #(
    .WAIT(WAIT)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(cnt_en),
    .done  (cnt_done)
  );

  // Bus fields are held at zero outside an access so reset and idle look the same.
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign mem_wstrb = mem_en ? wstrb_q : '0;
  assign if_rdata  = rdata_q;
  assign ls_rdata  = rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - scoreboard bench for riscv_mem_arbiter
//
// Fetches use addresses with bit 15 clear, loads/stores bit 15 set, so the two
// streams never alias and each queue's expected data is known at issue time.
module tb_riscv_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int WAIT   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [7:0]        ls_wstrb;
  logic              ls_ready;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        st;
    logic [63:0] d;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          en_total = 0;
  int          we_total = 0;
  int          ls_pulses = 0;
  int          if_rdy_cyc = 0;
  int          ls_rdy_cyc = 0;
  exp_t        if_q[$];
  exp_t        ls_q[$];
  int          order_q[$];
  logic [63:0] ref_mem[logic [15:0]];
  logic [63:0] dev_mem[logic [15:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5a5a, a + 16'h1234};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] w,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] dev_rd(input logic [15:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM model: read data is only valid in the WAIT-th enabled cycle; junk otherwise.
  int dev_run = 0;
  always @(negedge clk) begin
    if (mem_en) begin
      mem_rdata = (dev_run == WAIT - 1) ? dev_rd(mem_addr) : {$urandom, $urandom};
      if (mem_we) dev_mem[mem_addr] = merge(dev_rd(mem_addr), mem_wdata, mem_wstrb);
      dev_run++;
    end else begin
      dev_run = 0;
      mem_rdata = {$urandom, $urandom};
    end
  end

  // Monitor: access length, ready timing, bus contents and scoreboard data.
  int          en_len = 0;
  logic        owner_ls = 1'b0;
  logic        fall;
  logic [63:0] last_rd = '0;
  exp_t        e;
  always @(negedge clk) begin
    if (rst) begin
      en_len  = 0;
      last_rd = '0;
    end else begin
      fall = !mem_en && (en_len != 0);
      if (fall) check("en_length", en_len, WAIT);
      if (fall || if_ready || ls_ready) begin
        check("if_ready_timing", if_ready, fall && !owner_ls);
        check("ls_ready_timing", ls_ready, fall && owner_ls);
      end
      if (if_ready) begin
        if (if_q.size() == 0) check("if_unexpected_ready", 1, 0);
        else begin
          e = if_q.pop_front();
          check("if_rdata", if_rdata, e.d);
          last_rd = e.d;
          order_q.push_back(0);
        end
      end
      if (ls_ready) begin
        ls_pulses++;
        if (ls_q.size() == 0) check("ls_unexpected_ready", 1, 0);
        else begin
          e = ls_q.pop_front();
          check("ls_rdata", ls_rdata, e.st ? last_rd : e.d);
          if (!e.st) last_rd = e.d;
          order_q.push_back(1);
        end
      end
      if (fall) en_len = 0;
      if (mem_en) begin
        if (en_len == 0) owner_ls = mem_addr[15];
        en_len++;
        en_total++;
        if (mem_we) we_total++;
        if (owner_ls) begin
          check("ls_bus_addr_we", {mem_addr, mem_we}, {ls_addr, ls_we});
          check("ls_bus_wdata", mem_wdata, ls_wdata);
          check("ls_bus_wstrb", mem_wstrb, ls_wstrb);
        end else begin
          check("if_bus_addr_we", {mem_addr, mem_we}, {if_addr, 1'b0});
        end
      end
    end
  end

  task automatic do_if(input logic [15:0] a, output int lat);
    int t0, n;
    if_req  = 1'b1;
    if_addr = a;
    if_q.push_back('{1'b0, ref_rd(a)});
    t0 = cyc;
    n  = 0;
    do begin @(negedge clk); n++; end while (!if_ready && n < 200);
    check("if_handshake", if_ready, 1);
    lat = cyc - t0;
    if_rdy_cyc = cyc;
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_ls(input logic we, input logic [15:0] a, input logic [63:0] wd,
                       input logic [7:0] ws, output int lat);
    int t0, n;
    ls_req   = 1'b1;
    ls_we    = we;
    ls_addr  = a;
    ls_wdata = wd;
    ls_wstrb = ws;
    ls_q.push_back('{we, we ? 64'h0 : ref_rd(a)});
    if (we) ref_mem[a] = merge(ref_rd(a), wd, ws);
    t0 = cyc;
    n  = 0;
    do begin @(negedge clk); n++; end while (!ls_ready && n < 200);
    check("ls_handshake", ls_ready, 1);
    lat = cyc - t0;
    ls_rdy_cyc = cyc;
    @(posedge clk); #1;
    ls_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int lat, lat2, n0, en0, t_rst, n, ga, gb;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {mem_en, mem_we, if_ready, ls_ready}, 0);
    check("rst_rdata", if_rdata | ls_rdata, 0);
    check("rst_bus", {mem_addr, mem_wstrb} | mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch, then back-to-back fetches at full throughput.
    ref_mem[16'h0010] = 64'hDEAD_BEEF;
    dev_mem[16'h0010] = 64'hDEAD_BEEF;
    en0 = en_total;
    n0  = ls_pulses;
    do_if(16'h0010, lat);
    check("fetch_latency", lat, WAIT + 1);
    check("fetch_en_cycles", en_total - en0, WAIT);
    check("fetch_no_ls_ready", ls_pulses - n0, 0);
    for (int i = 0; i < 3; i++) begin
      do_if(16'h0100 + 16'(i), lat);
      check("b2b_fetch_latency", lat, WAIT + 1);
    end

    // Simultaneous requests right after reset: LS first, IF one slot later.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      do_if(16'h0040, lat);
      do_ls(1'b0, 16'h8040, 64'h0, 8'h00, lat2);
    join
    check("contest_ls_latency", lat2, WAIT + 1);
    check("contest_if_latency", lat, 2 * WAIT + 3);

    // Both held continuously: grants alternate starting with LS.
    order_q.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) do_ls(1'b0, 16'h8000 + 16'(i), 64'h0, 8'h00, lat2);
      end
      begin
        for (int j = 0; j < 3; j++) do_if(16'h0300 + 16'(j), lat);
      end
    join
    check("alt_count", order_q.size(), 6);
    for (int k = 0; k < 6 && k < order_q.size(); k++)
      check("alt_order", order_q[k], (k % 2 == 0) ? 1 : 0);

    // Partial-strobe store then readback of the merged word.
    en0 = we_total;
    do_ls(1'b1, 16'h8020, 64'h1122_3344_5566_7788, 8'h0F, lat);
    check("store_latency", lat, WAIT + 1);
    check("store_we_cycles", we_total - en0, WAIT);
    do_ls(1'b0, 16'h8020, 64'h0, 8'h00, lat);

    // Reset in the second BUSY cycle; held fetch is then served with full latency.
    fork
      do_if(16'h0200, lat);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_en && n < 50);
        check("rst_mid_saw_en", mem_en, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        t_rst = cyc;
        @(negedge clk);
        check("rst_mid_en", {mem_en, mem_we}, 0);
        check("rst_mid_ready", {if_ready, ls_ready}, 0);
        check("rst_mid_rdata", if_rdata, 0);
      end
    join
    check("rst_mid_latency", if_rdy_cyc - t_rst, WAIT + 1);

    // Randomized traffic on both ports with a no-starvation bound.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          ga = $urandom_range(0, 3);
          if (ga > 0) begin repeat (ga) @(posedge clk); #1; end
          do_if({1'b0, 15'($urandom)}, lat);
          check("if_fair_bound", lat <= 2 * WAIT + 3, 1);
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          gb = $urandom_range(0, 3);
          if (gb > 0) begin repeat (gb) @(posedge clk); #1; end
          do_ls(1'($urandom), {12'h800, 4'($urandom)}, {$urandom, $urandom},
                8'($urandom), lat2);
          check("ls_fair_bound", lat2 <= 2 * WAIT + 3, 1);
        end
      end
    join

    repeat (WAIT + 4) @(posedge clk);
    @(negedge clk);
    check("if_queue_drained", if_q.size(), 0);
    check("ls_queue_drained", ls_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
